// File: rtl/quad_to_serial_fifo_pkg.sv
// Shared sizing constants and types for the quad-in / sample-out buffer.
package quad_fifo_pkg;

   localparam int DEPTH   = 256;
   localparam int WIDTH   = 16;
   localparam int BANKS   = 4;
   localparam int BANK_AW = 6;

   typedef logic [WIDTH-1:0]         sample_t;
   // element 0 is the earliest sample of the beat
   typedef sample_t [BANKS-1:0]      quad_t;

endpackage

// File: rtl/quad_to_serial_fifo_if.sv
// Quad write bus, serial read bus and fill level of the quad buffer.
interface quad_to_serial_fifo_if;
   import quad_fifo_pkg::*;

   sample_t    in_data0;
   sample_t    in_data1;
   sample_t    in_data2;
   sample_t    in_data3;
   logic       in_valid;
   logic       in_ready;
   sample_t    out_data;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] level;

   modport master (
      output in_data0, in_data1, in_data2, in_data3, in_valid, out_ready,
      input  in_ready, out_data, out_valid, level
   );

   modport slave (
      input  in_data0, in_data1, in_data2, in_data3, in_valid, out_ready,
      output in_ready, out_data, out_valid, level
   );

endinterface

// File: rtl/ram16x64.sv
// 16x64 simple dual-port RAM, one write port, one registered read port.
module ram16x64 (
   input  logic        clock,
   input  logic        we,
   input  logic [5:0]  waddr,
   input  logic [15:0] wdata,
   input  logic        re,
   input  logic [5:0]  raddr,
   output logic [15:0] rdata
);

   logic [15:0] mem [64];

   // write and registered read share the single clock
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/quad_to_serial_fifo.sv
// Quad-wide write, one-sample-per-cycle read buffer over four interleaved
// banks. A 2-entry skid buffer at the output absorbs the 1-cycle RAM read
// latency so the sink sees a gap-free stream under backpressure.
module quad_to_serial_fifo
   import quad_fifo_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear,
   quad_to_serial_fifo_if.slave    bus
);

   logic [BANK_AW-1:0] wr_row;
   logic [7:0]         rd_ptr;
   logic [8:0]         mem_cnt;
   logic               rd_pend;
   logic [1:0]         rd_bank;
   sample_t            head_d;
   sample_t            tail_d;
   logic               head_v;
   logic               tail_v;
   logic [8:0]         level_q;

   quad_t              wr_quad;
   sample_t            rd_word [BANKS];
   sample_t            rd_data;
   logic               in_ready_i;
   logic               wr_en;
   logic               pop;
   logic               rd_issue;
   logic [1:0]         skid_cnt;
   logic [1:0]         occ_after;

   assign wr_quad    = {bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};
   assign in_ready_i = (mem_cnt <= 9'(DEPTH - 4));
   assign wr_en      = bus.in_valid & in_ready_i & ~clear;
   assign pop        = head_v & bus.out_ready & ~clear;

   // Occupancy outside the RAM once this cycle's output transfer is taken
   // out; counting the pop lets a read issue every cycle while streaming.
   assign skid_cnt   = {1'b0, head_v} + {1'b0, tail_v};
   assign occ_after  = skid_cnt + {1'b0, rd_pend} - {1'b0, pop};
   assign rd_issue   = (mem_cnt != 9'd0) & (occ_after < 2'd2) & ~clear;

   assign rd_data    = rd_word[rd_bank];

   assign bus.in_ready  = in_ready_i;
   assign bus.out_data  = head_d;
   assign bus.out_valid = head_v;
   assign bus.level     = level_q;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      ram16x64 u_ram (
         .clock (clock),
         .we    (wr_en),
         .waddr (wr_row),
         .wdata (wr_quad[b]),
         .re    (rd_issue && (rd_ptr[1:0] == 2'(b))),
         .raddr (rd_ptr[7:2]),
         .rdata (rd_word[b])
      );
   end

   // Pointers, RAM sample count and the single in-flight read tag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_row  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         rd_pend <= 1'b0;
         rd_bank <= '0;
      end else if (clear) begin
         wr_row  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         rd_pend <= 1'b0;
         rd_bank <= '0;
      end else begin
         if (wr_en) wr_row <= wr_row + 1'b1;
         if (rd_issue) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_bank <= rd_ptr[1:0];
         end
         rd_pend <= rd_issue;
         mem_cnt <= mem_cnt + (wr_en ? 9'd4 : 9'd0) - (rd_issue ? 9'd1 : 9'd0);
      end
   end

   // Skid buffer: head drives the output, tail catches a read that lands
   // while the head is stalled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_d <= '0;
         tail_d <= '0;
         head_v <= 1'b0;
         tail_v <= 1'b0;
      end else if (clear) begin
         head_d <= '0;
         tail_d <= '0;
         head_v <= 1'b0;
         tail_v <= 1'b0;
      end else if (pop) begin
         if (tail_v) begin
            head_d <= tail_d;
            head_v <= 1'b1;
            if (rd_pend) tail_d <= rd_data;
            else         tail_v <= 1'b0;
         end else if (rd_pend) begin
            head_d <= rd_data;
            head_v <= 1'b1;
         end else begin
            head_v <= 1'b0;
         end
      end else if (rd_pend) begin
         if (head_v) begin
            tail_d <= rd_data;
            tail_v <= 1'b1;
         end else begin
            head_d <= rd_data;
            head_v <= 1'b1;
         end
      end
   end

   // Total samples held: grows by a quad per write, shrinks per output.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    level_q <= '0;
      else if (clear)  level_q <= '0;
      else             level_q <= level_q + (wr_en ? 9'd4 : 9'd0) - (pop ? 9'd1 : 9'd0);
   end

endmodule

// File: tb/tb_quad_to_serial_fifo.sv
// Randomized self-checking bench for quad_to_serial_fifo; the reference is a
// plain sample queue holding everything accepted and not yet output.
module tb_quad_to_serial_fifo;
   import quad_fifo_pkg::*;

   logic clock = 1'b0;
   logic reset_n;
   logic clear;
   int   total = 0;
   int   bad   = 0;
   logic [15:0] q [$];

   quad_to_serial_fifo_if bus ();

   quad_to_serial_fifo dut (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic set_quad(input logic [15:0] a, b, c, d);
      bus.in_data0 = a;
      bus.in_data1 = b;
      bus.in_data2 = c;
      bus.in_data3 = d;
   endtask

   // advance one edge, updating the reference queue from the handshakes
   task automatic tick(output bit popped, output logic [15:0] got,
                       output logic [15:0] exp_s, output bit underflow);
      bit wr;
      bit pp;
      wr = bus.in_valid && bus.in_ready && !clear;
      pp = bus.out_valid && bus.out_ready && !clear;
      popped = pp;
      got = bus.out_data;
      exp_s = 16'h0;
      underflow = 1'b0;
      if (clear) begin
         q.delete();
      end else begin
         if (pp) begin
            if (q.size() == 0) underflow = 1'b1;
            else exp_s = q.pop_front();
         end
         if (wr) begin
            q.push_back(bus.in_data0);
            q.push_back(bus.in_data1);
            q.push_back(bus.in_data2);
            q.push_back(bus.in_data3);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      bit p, u;
      logic [15:0] g, e;
      reset_n = 1'b0;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      set_quad(16'h0, 16'h0, 16'h0, 16'h0);
      repeat (3) @(posedge clock);
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.level !== 9'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      total++; if (bus.out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); end
      reset_n = 1'b1;
      q.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(p, g, e, u);
         total++; if (bus.out_valid !== 1'b0 || p) begin bad++; $display("FAIL idle_out_valid cyc=%0d got=%b exp=0", i, bus.out_valid); end
      end
   endtask

   task automatic test_single();
      bit p, u;
      logic [15:0] g, e;
      logic [15:0] want [4];
      want[0] = 16'h1111; want[1] = 16'h2222; want[2] = 16'h3333; want[3] = 16'h4444;
      bus.out_ready = 1'b1;
      set_quad(want[0], want[1], want[2], want[3]);
      bus.in_valid = 1'b1;
      tick(p, g, e, u);
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_lat_n got=%b exp=0", bus.out_valid); end
      tick(p, g, e, u);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_lat_n1 got=%b exp=0", bus.out_valid); end
      tick(p, g, e, u);
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== want[0]) begin bad++; $display("FAIL single_lat_n2 got=%b/%h exp=1/%h", bus.out_valid, bus.out_data, want[0]); end
      for (int i = 0; i < 4; i++) begin
         tick(p, g, e, u);
         total++; if (!p || g !== want[i]) begin bad++; $display("FAIL single_order idx=%0d got=%b/%h exp=1/%h", i, p, g, want[i]); end
      end
      total++; if (bus.level !== 9'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drained level=%0d valid=%b exp=0/0", bus.level, bus.out_valid); end
   endtask

   task automatic test_fill();
      bit p, u;
      logic [15:0] g, e;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 64; i++) begin
         set_quad(16'(4*i), 16'(4*i+1), 16'(4*i+2), 16'(4*i+3));
         bus.in_valid = 1'b1;
         total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready quad=%0d got=0 exp=1", i); end
         tick(p, g, e, u);
      end
      bus.in_valid = 1'b0;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
      total++; if (bus.level !== 9'd256) begin bad++; $display("FAIL full_level got=%0d exp=256", bus.level); end
      set_quad(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      bus.in_valid = 1'b1;
      repeat (3) tick(p, g, e, u);
      bus.in_valid = 1'b0;
      total++; if (bus.level !== 9'd256) begin bad++; $display("FAIL full_reject level=%0d exp=256", bus.level); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         tick(p, g, e, u);
         total++; if (!p || g !== 16'(i)) begin bad++; $display("FAIL fill_readback idx=%0d got=%b/%h exp=1/%h", i, p, g, 16'(i)); end
      end
      total++; if (bus.level !== 9'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL fill_drained level=%0d valid=%b exp=0/0", bus.level, bus.out_valid); end
   endtask

   task automatic test_stream();
      bit p, u, started;
      logic [15:0] g, e;
      started = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 300; k++) begin
         set_quad(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         for (int c = 0; c < 4; c++) begin
            bus.in_valid = (c == 0);
            if (bus.out_valid) started = 1'b1;
            total++; if (bus.level > 9'd8 || bus.level !== 9'(q.size())) begin bad++; $display("FAIL stream_level got=%0d model=%0d", bus.level, q.size()); end
            if (started && q.size() > 0) begin
               total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_gap quad=%0d got=0 exp=1", k); end
            end
            tick(p, g, e, u);
            if (p) begin
               total++; if (u || g !== e) begin bad++; $display("FAIL stream_data quad=%0d got=%h exp=%h", k, g, e); end
            end
         end
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         tick(p, g, e, u);
         if (p) begin
            total++; if (u || g !== e) begin bad++; $display("FAIL stream_tail got=%h exp=%h", g, e); end
         end
      end
      total++; if (q.size() != 0 || bus.level !== 9'd0) begin bad++; $display("FAIL stream_drain left=%0d level=%0d exp=0", q.size(), bus.level); end
   endtask

   task automatic test_random();
      bit p, u;
      logic [15:0] g, e;
      for (int i = 0; i < 3000; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         set_quad(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         total++; if (bus.level !== 9'(q.size())) begin bad++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, bus.level, q.size()); end
         if (q.size() > 254) begin
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rand_in_ready_full cyc=%0d held=%0d got=1 exp=0", i, q.size()); end
         end
         if (q.size() <= 252) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rand_in_ready_room cyc=%0d held=%0d got=0 exp=1", i, q.size()); end
         end
         if (q.size() == 0) begin
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rand_empty_valid cyc=%0d got=1 exp=0", i); end
         end
         tick(p, g, e, u);
         if (p) begin
            total++; if (u || g !== e) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, g, e); end
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 400 && q.size() > 0; i++) begin
         tick(p, g, e, u);
         if (p) begin
            total++; if (u || g !== e) begin bad++; $display("FAIL rand_drain_data got=%h exp=%h", g, e); end
         end
      end
      total++; if (q.size() != 0 || bus.level !== 9'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL rand_drain left=%0d level=%0d valid=%b", q.size(), bus.level, bus.out_valid); end
   endtask

   // write 0xA..0xD after a flush and expect exactly those, in order
   task automatic check_abcd(input string tag);
      bit p, u;
      logic [15:0] g, e;
      int n;
      logic [15:0] want [4];
      want[0] = 16'h000A; want[1] = 16'h000B; want[2] = 16'h000C; want[3] = 16'h000D;
      bus.out_ready = 1'b1;
      set_quad(want[0], want[1], want[2], want[3]);
      bus.in_valid = 1'b1;
      tick(p, g, e, u);
      bus.in_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && n < 4; i++) begin
         tick(p, g, e, u);
         if (p) begin
            total++; if (g !== want[n]) begin bad++; $display("FAIL %s_fresh idx=%0d got=%h exp=%h", tag, n, g, want[n]); end
            n++;
         end
      end
      total++; if (n != 4 || bus.level !== 9'd0) begin bad++; $display("FAIL %s_count got=%0d level=%0d exp=4/0", tag, n, bus.level); end
   endtask

   task automatic test_clear();
      bit p, u;
      logic [15:0] g, e;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_quad(16'h100 + 16'(i), 16'h200, 16'h300, 16'h400);
         bus.in_valid = 1'b1;
         tick(p, g, e, u);
      end
      bus.in_valid = 1'b0;
      repeat (3) tick(p, g, e, u);
      clear = 1'b1;
      bus.in_valid = 1'b1;
      set_quad(16'h9999, 16'h9999, 16'h9999, 16'h9999);
      tick(p, g, e, u);
      clear = 1'b0;
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0 || bus.level !== 9'd0) begin bad++; $display("FAIL clear_state valid=%b level=%0d exp=0/0", bus.out_valid, bus.level); end
      total++; if (bus.out_data !== 16'h0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL clear_outputs data=%h ready=%b exp=0000/1", bus.out_data, bus.in_ready); end
      check_abcd("clear");
   endtask

   task automatic test_reset_mid();
      bit p, u;
      logic [15:0] g, e;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_quad(16'h500 + 16'(i), 16'h600, 16'h700, 16'h800);
         bus.in_valid = 1'b1;
         tick(p, g, e, u);
      end
      bus.in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0 || bus.level !== 9'd0) begin bad++; $display("FAIL async_reset valid=%b level=%0d exp=0/0", bus.out_valid, bus.level); end
      q.delete();
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;
      total++; if (bus.out_data !== 16'h0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_outputs data=%h ready=%b exp=0000/1", bus.out_data, bus.in_ready); end
      check_abcd("reset");
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_stream();
      test_random();
      test_clear();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
